// File: rtl/sram_wrapper_sky130_dual_pkg.sv
// Shared constants for the tiled sky130 dual-port SRAM wrapper.
// Macro geometry plus helpers that derive the bank count and check parameter legality.
package sram_wrapper_sky130_dual_pkg;

   localparam int unsigned MACRO_ADDRESS_SIZE = 9;
   localparam int unsigned MACRO_BYTE_COUNT   = 4;
   localparam int unsigned MACRO_DATA_WIDTH   = 8 * MACRO_BYTE_COUNT;

   function automatic bit params_ok(int unsigned byte_count, int unsigned address_size);
      return (byte_count != 0) && (byte_count % MACRO_BYTE_COUNT == 0) &&
             (address_size >= MACRO_ADDRESS_SIZE);
   endfunction

   function automatic int unsigned bank_count(int unsigned address_size);
      return 32'd1 << (address_size - MACRO_ADDRESS_SIZE);
   endfunction

endpackage

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// Behavioural stand-in for the OpenRAM sky130 1rw1r 32x512 macro (byte-masked port 0,
// read-only port 1, outputs registered on the clock edge, dout holds when not read).
module sky130_sram_2kbyte_1rw1r_32x512_8 (
`ifdef USE_POWER_PINS
   inout  wire         vccd1,
   inout  wire         vssd1,
`endif
   input  logic        clk0,
   input  logic        csb0,
   input  logic        web0,
   input  logic [3:0]  wmask0,
   input  logic [8:0]  addr0,
   input  logic [31:0] din0,
   output logic [31:0] dout0,
   input  logic        clk1,
   input  logic        csb1,
   input  logic [8:0]  addr1,
   output logic [31:0] dout1
);

   logic [31:0] mem [512];

   always_ff @(posedge clk0) begin
      if (!csb0) begin
         if (!web0) begin
            for (int i = 0; i < 4; i++) begin
               if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
            end
         end else begin
            dout0 <= mem[addr0];
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (!csb1) dout1 <= mem[addr1];
   end

endmodule

// File: rtl/sram_bank_sky130.sv
// One 512-word bank: ByteCount/4 macros side by side sharing select, write enable and
// address; mask and data are sliced per 32-bit column.
module sram_bank_sky130
   import sram_wrapper_sky130_dual_pkg::*;
#(
   parameter int unsigned ByteCount = 4
) (
`ifdef USE_POWER_PINS
   inout  wire                          VPWR,
   inout  wire                          VGND,
`endif
   input  logic                         clk_i,
   input  logic                         p_csb_i,
   input  logic                         p_web_i,
   input  logic [ByteCount-1:0]         p_wmask_i,
   input  logic [MACRO_ADDRESS_SIZE-1:0] p_addr_i,
   input  logic [8*ByteCount-1:0]       p_din_i,
   output logic [8*ByteCount-1:0]       p_dout_o,
   input  logic                         s_csb_i,
   input  logic [MACRO_ADDRESS_SIZE-1:0] s_addr_i,
   output logic [8*ByteCount-1:0]       s_dout_o
);

   localparam int unsigned Columns = ByteCount / MACRO_BYTE_COUNT;

   for (genvar c = 0; c < Columns; c++) begin : g_col
      sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
`ifdef USE_POWER_PINS
         .vccd1  (VPWR),
         .vssd1  (VGND),
`endif
         .clk0   (clk_i),
         .csb0   (p_csb_i),
         .web0   (p_web_i),
         .wmask0 (p_wmask_i[MACRO_BYTE_COUNT*c +: MACRO_BYTE_COUNT]),
         .addr0  (p_addr_i),
         .din0   (p_din_i[MACRO_DATA_WIDTH*c +: MACRO_DATA_WIDTH]),
         .dout0  (p_dout_o[MACRO_DATA_WIDTH*c +: MACRO_DATA_WIDTH]),
         .clk1   (clk_i),
         .csb1   (s_csb_i),
         .addr1  (s_addr_i),
         .dout1  (s_dout_o[MACRO_DATA_WIDTH*c +: MACRO_DATA_WIDTH])
      );
   end

endmodule

// File: rtl/sram_wrapper_sky130_dual.sv
// Dual-port SRAM wrapper: bank decode, write/read collision stall on the secondary port,
// registered bank selection and hold registers so read data stays stable between returns.
module sram_wrapper_sky130_dual
   import sram_wrapper_sky130_dual_pkg::*;
#(
   parameter int unsigned BYTE_COUNT   = 4,
   parameter int unsigned ADDRESS_SIZE = 9
) (
`ifdef USE_POWER_PINS
   inout  wire                      VPWR,
   inout  wire                      VGND,
`endif
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     primarySelect,
   input  logic                     primaryWriteEnable,
   input  logic [BYTE_COUNT-1:0]    primaryWriteMask,
   input  logic [ADDRESS_SIZE-1:0]  primaryAddress,
   input  logic [8*BYTE_COUNT-1:0]  primaryDataWrite,
   output logic [8*BYTE_COUNT-1:0]  primaryDataRead,
   output logic                     primaryReadValid,
   input  logic                     secondarySelect,
   input  logic [ADDRESS_SIZE-1:0]  secondaryAddress,
   output logic                     secondaryStall,
   output logic [8*BYTE_COUNT-1:0]  secondaryDataRead,
   output logic                     secondaryReadValid
);

   localparam int unsigned DataWidth = 8 * BYTE_COUNT;
   localparam bit          ParamsOk  = params_ok(BYTE_COUNT, ADDRESS_SIZE);
   localparam int unsigned NumBanks  = ParamsOk ? bank_count(ADDRESS_SIZE) : 1;
   localparam int unsigned BankWidth =
      (ADDRESS_SIZE > MACRO_ADDRESS_SIZE) ? ADDRESS_SIZE - MACRO_ADDRESS_SIZE : 1;
   localparam int unsigned NumSlots  = 1 << BankWidth;

   logic [BankWidth-1:0] p_bank, s_bank;
   logic                 collision, p_accept, s_accept;
   logic [DataWidth-1:0] p_dout [NumSlots];
   logic [DataWidth-1:0] s_dout [NumSlots];
   logic [DataWidth-1:0] p_rdata, s_rdata;
   logic                 p_valid, s_valid;

   logic                 p_pend_d, p_pend_q, s_pend_d, s_pend_q;
   logic [BankWidth-1:0] p_bank_d, p_bank_q, s_bank_d, s_bank_q;
   logic [DataWidth-1:0] p_hold_d, p_hold_q, s_hold_d, s_hold_q;

   if (ADDRESS_SIZE > MACRO_ADDRESS_SIZE) begin : g_bank_idx
      assign p_bank = primaryAddress[ADDRESS_SIZE-1:MACRO_ADDRESS_SIZE];
      assign s_bank = secondaryAddress[ADDRESS_SIZE-1:MACRO_ADDRESS_SIZE];
   end else begin : g_single_bank
      assign p_bank = '0;
      assign s_bank = '0;
   end

   assign collision = secondarySelect & primarySelect & primaryWriteEnable &
                      (secondaryAddress == primaryAddress);
   assign secondaryStall = collision;

   // Reset gates both ports so no macro is selected while rst is high.
   assign p_accept = primarySelect & ~rst;
   assign s_accept = secondarySelect & ~collision & ~rst;

   if (ParamsOk) begin : g_banks
      for (genvar b = 0; b < NumBanks; b++) begin : g_bank
         logic p_csb, s_csb;
         assign p_csb = ~(p_accept && (p_bank == BankWidth'(b)));
         assign s_csb = ~(s_accept && (s_bank == BankWidth'(b)));

         sram_bank_sky130 #(
            .ByteCount (BYTE_COUNT)
         ) u_bank (
`ifdef USE_POWER_PINS
            .VPWR      (VPWR),
            .VGND      (VGND),
`endif
            .clk_i     (clk),
            .p_csb_i   (p_csb),
            .p_web_i   (~primaryWriteEnable),
            .p_wmask_i (primaryWriteMask),
            .p_addr_i  (primaryAddress[MACRO_ADDRESS_SIZE-1:0]),
            .p_din_i   (primaryDataWrite),
            .p_dout_o  (p_dout[b]),
            .s_csb_i   (s_csb),
            .s_addr_i  (secondaryAddress[MACRO_ADDRESS_SIZE-1:0]),
            .s_dout_o  (s_dout[b])
         );
      end
      for (genvar b = NumBanks; b < NumSlots; b++) begin : g_unused_slot
         assign p_dout[b] = '0;
         assign s_dout[b] = '0;
      end
   end else begin : g_no_banks
      for (genvar b = 0; b < NumSlots; b++) begin : g_zero_slot
         assign p_dout[b] = '0;
         assign s_dout[b] = '0;
      end
   end

   assign p_rdata = p_dout[p_bank_q];
   assign s_rdata = s_dout[s_bank_q];
   assign p_valid = p_pend_q & ~rst;
   assign s_valid = s_pend_q & ~rst;

   assign primaryReadValid   = p_valid;
   assign secondaryReadValid = s_valid;
   assign primaryDataRead    = p_valid ? p_rdata : p_hold_q;
   assign secondaryDataRead  = s_valid ? s_rdata : s_hold_q;

   always_comb begin
      p_pend_d = p_accept & ~primaryWriteEnable;
      p_bank_d = p_pend_d ? p_bank : p_bank_q;
      p_hold_d = p_valid ? p_rdata : p_hold_q;
      s_pend_d = s_accept;
      s_bank_d = s_pend_d ? s_bank : s_bank_q;
      s_hold_d = s_valid ? s_rdata : s_hold_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_pend_q <= 1'b0;
         p_bank_q <= '0;
         p_hold_q <= '0;
         s_pend_q <= 1'b0;
         s_bank_q <= '0;
         s_hold_q <= '0;
      end else begin
         p_pend_q <= p_pend_d;
         p_bank_q <= p_bank_d;
         p_hold_q <= p_hold_d;
         s_pend_q <= s_pend_d;
         s_bank_q <= s_bank_d;
         s_hold_q <= s_hold_d;
      end
   end

endmodule

// File: tb/tb_sram_wrapper_sky130_dual.sv
// Scenario bench for the dual-port SRAM wrapper (8-byte words, two banks): a reference
// memory produces expected read data, queued at issue and compared on return.
module tb_sram_wrapper_sky130_dual;

   localparam int unsigned BC = 8;
   localparam int unsigned AS = 10;
   localparam int unsigned DW = 8 * BC;

   logic          clk = 1'b0;
   logic          rst;
   logic          primarySelect, primaryWriteEnable;
   logic [BC-1:0] primaryWriteMask;
   logic [AS-1:0] primaryAddress, secondaryAddress;
   logic [DW-1:0] primaryDataWrite, primaryDataRead, secondaryDataRead;
   logic          primaryReadValid, secondarySelect, secondaryStall, secondaryReadValid;

   always #5 clk = ~clk;

   sram_wrapper_sky130_dual #(
      .BYTE_COUNT   (BC),
      .ADDRESS_SIZE (AS)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .primarySelect      (primarySelect),
      .primaryWriteEnable (primaryWriteEnable),
      .primaryWriteMask   (primaryWriteMask),
      .primaryAddress     (primaryAddress),
      .primaryDataWrite   (primaryDataWrite),
      .primaryDataRead    (primaryDataRead),
      .primaryReadValid   (primaryReadValid),
      .secondarySelect    (secondarySelect),
      .secondaryAddress   (secondaryAddress),
      .secondaryStall     (secondaryStall),
      .secondaryDataRead  (secondaryDataRead),
      .secondaryReadValid (secondaryReadValid)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] ref_mem [int];
   logic [DW-1:0] p_exp [$];
   logic [DW-1:0] s_exp [$];
   logic [DW-1:0] e, es;

   function automatic logic [DW-1:0] merge(logic [DW-1:0] old_w, logic [DW-1:0] new_w,
                                           logic [BC-1:0] mask);
      logic [DW-1:0] r = old_w;
      for (int i = 0; i < BC; i++) if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      primarySelect      = 1'b0;
      primaryWriteEnable = 1'b0;
      primaryWriteMask   = '0;
      primaryAddress     = '0;
      primaryDataWrite   = '0;
      secondarySelect    = 1'b0;
      secondaryAddress   = '0;
   endtask

   task automatic drive_write(input logic [AS-1:0] a, input logic [DW-1:0] d,
                              input logic [BC-1:0] m);
      logic [DW-1:0] old_w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
      primarySelect      = 1'b1;
      primaryWriteEnable = 1'b1;
      primaryWriteMask   = m;
      primaryAddress     = a;
      primaryDataWrite   = d;
      ref_mem[int'(a)]   = merge(old_w, d, m);
   endtask

   task automatic drive_pread(input logic [AS-1:0] a);
      primarySelect      = 1'b1;
      primaryWriteEnable = 1'b0;
      primaryAddress     = a;
      p_exp.push_back(ref_mem[int'(a)]);
   endtask

   task automatic drive_sread(input logic [AS-1:0] a);
      secondarySelect  = 1'b1;
      secondaryAddress = a;
      s_exp.push_back(ref_mem[int'(a)]);
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if (primaryReadValid !== 1'b0 || secondaryReadValid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got p=%b s=%b, expected 0 0",
                  primaryReadValid, secondaryReadValid);
      end
      n_checks++;
      if (primaryDataRead !== '0 || secondaryDataRead !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got p=%h s=%h, expected 0", primaryDataRead,
                  secondaryDataRead);
      end
      n_checks++;
      if (secondaryStall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall: got %b, expected 0", secondaryStall);
      end
   endtask

   task automatic test_write_read();
      idle();
      drive_write(10'h3FF, 64'h1122334455667788, 8'hFF);
      tick();
      n_checks++;
      if (primaryReadValid !== 1'b0 || primaryDataRead !== '0) begin
         n_fail++;
         $display("FAIL write_no_strobe: got valid=%b data=%h, expected 0 0",
                  primaryReadValid, primaryDataRead);
      end
      idle();
      drive_write(10'h000, 64'hCAFEBABE0BADF00D, 8'hFF);
      tick();
      idle();
      drive_pread(10'h3FF);
      drive_sread(10'h3FF);
      tick();
      e = p_exp.pop_front();
      n_checks++;
      if (primaryReadValid !== 1'b1 || primaryDataRead !== e) begin
         n_fail++;
         $display("FAIL p_read_3ff: got valid=%b data=%h, expected 1 %h",
                  primaryReadValid, primaryDataRead, e);
      end
      es = s_exp.pop_front();
      n_checks++;
      if (secondaryReadValid !== 1'b1 || secondaryDataRead !== es) begin
         n_fail++;
         $display("FAIL s_read_3ff: got valid=%b data=%h, expected 1 %h",
                  secondaryReadValid, secondaryDataRead, es);
      end
      idle();
      drive_pread(10'h000);
      tick();
      e = p_exp.pop_front();
      n_checks++;
      if (primaryReadValid !== 1'b1 || primaryDataRead !== e) begin
         n_fail++;
         $display("FAIL p_read_000: got valid=%b data=%h, expected 1 %h",
                  primaryReadValid, primaryDataRead, e);
      end
   endtask

   task automatic test_masked_write();
      idle();
      drive_write(10'h020, 64'hAAAAAAAABBBBBBBB, 8'hFF);
      tick();
      idle();
      drive_write(10'h020, 64'hFFFFFFFF00000000, 8'h0F);
      tick();
      idle();
      drive_pread(10'h020);
      tick();
      e = p_exp.pop_front();
      n_checks++;
      if (primaryReadValid !== 1'b1 || primaryDataRead !== 64'hAAAAAAAA00000000) begin
         n_fail++;
         $display("FAIL masked_write: got valid=%b data=%h, expected 1 aaaaaaaa00000000",
                  primaryReadValid, primaryDataRead);
      end
   endtask

   task automatic test_collision();
      idle();
      drive_write(10'h105, 64'h0105010501050105, 8'hFF);
      secondarySelect  = 1'b1;
      secondaryAddress = 10'h105;
      #1;
      n_checks++;
      if (secondaryStall !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_stall: got %b, expected 1", secondaryStall);
      end
      tick();
      idle();
      n_checks++;
      if (secondaryReadValid !== 1'b0) begin
         n_fail++;
         $display("FAIL stalled_no_valid: got %b, expected 0", secondaryReadValid);
      end
      drive_sread(10'h105);
      #1;
      n_checks++;
      if (secondaryStall !== 1'b0) begin
         n_fail++;
         $display("FAIL retry_stall: got %b, expected 0", secondaryStall);
      end
      tick();
      es = s_exp.pop_front();
      n_checks++;
      if (secondaryReadValid !== 1'b1 || secondaryDataRead !== es) begin
         n_fail++;
         $display("FAIL retry_data: got valid=%b data=%h, expected 1 %h",
                  secondaryReadValid, secondaryDataRead, es);
      end
      idle();
      drive_sread(10'h105);
      drive_write(10'h106, 64'h0106010601060106, 8'hFF);
      #1;
      n_checks++;
      if (secondaryStall !== 1'b0) begin
         n_fail++;
         $display("FAIL no_collision_stall: got %b, expected 0", secondaryStall);
      end
      tick();
      es = s_exp.pop_front();
      n_checks++;
      if (secondaryReadValid !== 1'b1 || secondaryDataRead !== es) begin
         n_fail++;
         $display("FAIL write_other_read: got valid=%b data=%h, expected 1 %h",
                  secondaryReadValid, secondaryDataRead, es);
      end
   endtask

   task automatic test_dual_read();
      idle();
      drive_write(10'h010, 64'h0000001000000010, 8'hFF);
      tick();
      idle();
      drive_write(10'h210, 64'h0000021000000210, 8'hFF);
      tick();
      idle();
      drive_pread(10'h010);
      drive_sread(10'h210);
      tick();
      e  = p_exp.pop_front();
      es = s_exp.pop_front();
      n_checks++;
      if (primaryReadValid !== 1'b1 || primaryDataRead !== e ||
          secondaryReadValid !== 1'b1 || secondaryDataRead !== es) begin
         n_fail++;
         $display("FAIL dual_read: got p=%b/%h s=%b/%h, expected 1/%h 1/%h",
                  primaryReadValid, primaryDataRead, secondaryReadValid,
                  secondaryDataRead, e, es);
      end
   endtask

   task automatic test_back_to_back();
      logic [AS-1:0] addrs [5] = '{10'h3FF, 10'h000, 10'h010, 10'h210, 10'h020};
      for (int i = 0; i < 5; i++) begin
         idle();
         drive_pread(addrs[i]);
         drive_sread(addrs[4-i]);
         tick();
         e  = p_exp.pop_front();
         es = s_exp.pop_front();
         n_checks++;
         if (primaryReadValid !== 1'b1 || primaryDataRead !== e ||
             secondaryReadValid !== 1'b1 || secondaryDataRead !== es) begin
            n_fail++;
            $display("FAIL back_to_back_%0d: got p=%b/%h s=%b/%h, expected 1/%h 1/%h", i,
                     primaryReadValid, primaryDataRead, secondaryReadValid,
                     secondaryDataRead, e, es);
         end
      end
   endtask

   task automatic test_hold();
      idle();
      drive_pread(10'h210);
      drive_sread(10'h010);
      tick();
      e  = p_exp.pop_front();
      es = s_exp.pop_front();
      for (int i = 1; i <= 5; i++) begin
         if (i == 1) idle();
         if (i == 3) drive_write(10'h211, 64'h5555555555555555, 8'hFF);
         if (i == 4) idle();
         n_checks++;
         if (primaryDataRead !== e || secondaryDataRead !== es ||
             primaryReadValid !== (i == 1) || secondaryReadValid !== (i == 1)) begin
            n_fail++;
            $display("FAIL hold_n%0d: got p=%b/%h s=%b/%h, expected %0d/%h %0d/%h", i,
                     primaryReadValid, primaryDataRead, secondaryReadValid,
                     secondaryDataRead, i == 1, e, i == 1, es);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      idle();
      drive_pread(10'h3FF);
      drive_sread(10'h000);
      tick();
      void'(p_exp.pop_front());
      void'(s_exp.pop_front());
      idle();
      rst = 1'b1;
      #1;
      n_checks++;
      if (primaryReadValid !== 1'b0 || secondaryReadValid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_suppress: got p=%b s=%b, expected 0 0",
                  primaryReadValid, secondaryReadValid);
      end
      drive_write(10'h3FF, 64'hDEADDEADDEADDEAD, 8'hFF);
      ref_mem[int'(10'h3FF)] = 64'h1122334455667788;
      tick();
      rst = 1'b0;
      idle();
      #1;
      n_checks++;
      if (primaryDataRead !== '0 || secondaryDataRead !== '0 ||
          primaryReadValid !== 1'b0 || secondaryReadValid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_clear: got p=%b/%h s=%b/%h, expected 0/0 0/0",
                  primaryReadValid, primaryDataRead, secondaryReadValid, secondaryDataRead);
      end
      drive_pread(10'h3FF);
      tick();
      e = p_exp.pop_front();
      n_checks++;
      if (primaryReadValid !== 1'b1 || primaryDataRead !== e) begin
         n_fail++;
         $display("FAIL reset_ignores_write: got valid=%b data=%h, expected 1 %h",
                  primaryReadValid, primaryDataRead, e);
      end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_write_read();
      test_masked_write();
      test_collision();
      test_dual_read();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
